// File: rtl/instr_buffer.sv
// instr_buffer: circular FIFO between fetch and decode/dispatch.
// Accepts one N-wide bundle per cycle and presents the N oldest entries to
// decode, which consumes any prefix of them. Flushes fully on redirect.
// Optional build macro IB_PERF_CNT_EN adds 32-bit saturating perf counters.
module instr_buffer #(
  parameter int N     = 4,
  parameter int DEPTH = 16,
  parameter int EW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_bundle_valid_i,
  input  logic [N-1:0][EW-1:0]       fetch_entries_i,
  output logic                       ib_stall_o,
  output logic [N-1:0]               dispatch_valid_o,
  output logic [N-1:0][EW-1:0]       dispatch_entries_o,
  input  logic [$clog2(N+1)-1:0]     dispatch_take_i,
  input  logic                       flush_i,
  output logic [CW-1:0]              count_o,
  output logic [CW-1:0]              free_o
`ifdef IB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cycles_o,
  output logic [31:0]                perf_empty_cycles_o,
  output logic [31:0]                perf_flush_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic          enq;

  // Stall and dispatch view come only from registered state, so fetch and
  // decode never see a combinational path through this block.
  always_comb begin
    free_o     = CW'(DEPTH) - count_q;
    count_o    = count_q;
    ib_stall_o = (free_o < CW'(N));
    enq        = fetch_bundle_valid_i && !ib_stall_o && !flush_i;
    for (int i = 0; i < N; i++) begin
      dispatch_valid_o[i]   = (CW'(i) < count_q);
      dispatch_entries_o[i] = mem_q[head_q + PW'(i)];
    end
  end

  // Next-state: flush wins over enqueue and dequeue; pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        for (int i = 0; i < N; i++) begin
          mem_d[tail_q + PW'(i)] = fetch_entries_i[i];
        end
        tail_d = tail_q + PW'(N);
      end
      head_d  = head_q + PW'(dispatch_take_i);
      count_d = count_q + (enq ? CW'(N) : '0) - CW'(dispatch_take_i);
    end
  end

  // Control registers; reset behaves like a flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage has no reset; only lanes below count are ever trusted.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef IB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters; flush deliberately does not clear them.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_empty_d = perf_empty_q;
    perf_flush_d = perf_flush_q;
    if (fetch_bundle_valid_i && ib_stall_o && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    if ((count_q == '0) && !flush_i && (perf_empty_q != '1))
      perf_empty_d = perf_empty_q + 32'd1;
    if (flush_i && (perf_flush_q != '1))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  // Perf counter registers, cleared by reset only.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_empty_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_empty_q <= perf_empty_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_empty_cycles_o = perf_empty_q;
  assign perf_flush_cnt_o    = perf_flush_q;
`endif

`ifndef SYNTHESIS
  // Decode may never take more entries than are valid; count stays bounded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ((int'(dispatch_take_i) <= N) && (CW'(dispatch_take_i) <= count_q))
        else $error("instr_buffer: take %0d exceeds valid entries %0d",
                    dispatch_take_i, count_q);
      assert (count_q <= CW'(DEPTH))
        else $error("instr_buffer: count %0d above depth", count_q);
    end
  end
`endif

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Circular FIFO between the fetch stage and decode/dispatch.
- Accepts one N-wide fetch bundle per cycle. Presents up to N oldest entries, in program order, to decode.
- Decode consumes any prefix of 0..N entries per cycle.
- Drives the stall that gates fetch bundle acceptance.
- Flushes completely on a back-end redirect.

Parameters:
- N, `N: bundle width in entries, both in and out.
- DEPTH, 16: buffer entries. Power of two, DEPTH >= 2*N.
- CW, $clog2(DEPTH+1): width of occupancy counters.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- fetch_bundle_valid_i  input  1  fetch presents a full N-entry bundle
- fetch_entries_i  input  N x FETCH_ENTRY  bundle; lane 0 is oldest
- ib_stall_o  output  1  buffer cannot accept a bundle this cycle
- dispatch_valid_o  output  N  lane i holds the i-th oldest buffered entry
- dispatch_entries_o  output  N x FETCH_ENTRY  oldest N entries
- dispatch_take_i  input  $clog2(N+1)  number of oldest entries consumed this cycle
- flush_i  input  1  redirect; discard all contents
- count_o  output  CW  current occupancy
- free_o  output  CW  DEPTH - count

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- State:
  - head_ptr, tail_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: CW bits.
  - storage: DEPTH x FETCH_ENTRY.
- Reset: head = tail = count = 0; ib_stall_o = 0; dispatch_valid_o = 0; count_o = 0; free_o = DEPTH. Storage contents are don't-care.
- Stall:
  - ib_stall_o = (free < N). Combinational from registered count only; it does not credit same-cycle dequeue.
  - Fetch only sees a registered-state function, so there is no combinational loop.
- Enqueue (enq) = fetch_bundle_valid_i && !ib_stall_o && !flush_i.
  - On enq, write lanes 0..N-1 to storage[(tail+i) mod DEPTH].
  - tail += N (mod DEPTH).
- Dispatch outputs are combinational from registered state, with zero latency from buffer to decode:
  - dispatch_entries_o[i] = storage[(head+i) mod DEPTH].
  - dispatch_valid_o[i] = (i < count).
- Enqueue-to-visibility latency is 1 cycle. A bundle accepted at edge k is visible on dispatch outputs after edge k+1. There is no bypass when empty.
- Dequeue: when !flush_i, head += dispatch_take_i (mod DEPTH).
  - dispatch_take_i > number of valid lanes is illegal. Assert in simulation.
- Count update: count_next = count + (enq ? N : 0) - take. Simultaneous enq and take is legal, including when full-minus-N.
- Flush:
  - flush_i has priority over enq and take in the same cycle.
  - Next cycle: head = tail = count = 0, all dispatch_valid_o = 0, ib_stall_o = 0.
  - A bundle presented in the flush cycle is dropped.
- Reset mid-operation: identical to flush, and takes priority over flush_i.
- Wrap-around: a bundle straddling DEPTH-1 -> 0 is written and read correctly. Pointers never compare; count alone determines full/empty.
- Invariant: 0 <= count <= DEPTH. Assert.

Optional Feature:
- Macro: IB_PERF_CNT_EN.
- When defined, add 32-bit saturating output counters, cleared by reset only (not by flush):
  - perf_stall_cycles_o: cycles with fetch_bundle_valid_i && ib_stall_o.
  - perf_empty_cycles_o: cycles with count == 0 && !flush_i.
  - perf_flush_cnt_o: cycles with flush_i.
- When undefined, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan (N=3, DEPTH=8):
- Reset then idle → count_o=0, free_o=8, ib_stall_o=0, dispatch_valid_o=3'b000.
- Three consecutive bundles A, B, C, take=0 → after A and B, count=6; ib_stall_o=1 (free=2<3); C is not accepted; count stays 6.
- Count=6, bundle C presented with take=3 → stall still 1 (no dequeue credit), C dropped, count=3. The next cycle accepts C, giving count=6, with dispatch order preserved (B0, B1, B2).
- Fill past index 7: head=6, tail=6, count=0, enqueue bundle X → X0, X1, X2 stored at 6, 7, 0. The next cycle shows X0, X1, X2 on lanes 0..2, valid=3'b111.
- Count=5, enq and take=2 in the same cycle as flush_i=1 → next cycle count=0, valid=000, stall=0, head=tail=0.
- Count=2, take=2, enq of bundle Y → next count=3, lanes show Y0, Y1, Y2. With IB_PERF_CNT_EN, perf_flush_cnt_o increments exactly once in the previous test.
